// File: rtl/pck_injct_traffic_gen_pkg.sv
// Shared types, sizing and helpers for the packet-injector traffic generator
// (2x2 mesh endpoint addressing, two virtual channels).
package pck_injct_traffic_gen_pkg;

   localparam string TOPOLOGY = "MESH";
   localparam int T1       = 2;
   localparam int T2       = 2;
   localparam int T3       = 1;
   localparam int NE       = T1 * T2;
   localparam int NEw      = $clog2(NE);
   localparam int V        = 2;
   localparam int Xw       = (T1 > 1) ? $clog2(T1) : 1;
   localparam int Yw       = (T2 > 1) ? $clog2(T2) : 1;
   localparam int EAw      = Xw + Yw;
   localparam int Fpay     = 64;
   localparam int PCK_SIZw = 8;
   localparam int Cw       = 1;
   localparam int WEIGHTw  = 4;

   typedef struct packed {
      logic [Fpay-1:0]     data;
      logic [PCK_SIZw-1:0] size;
      logic [EAw-1:0]      endp_addr;
      logic [Cw-1:0]       class_num;
      logic [WEIGHTw-1:0]  init_weight;
      logic [V-1:0]        vc;
      logic                pck_wr;
      logic [V-1:0]        ready;
   } pck_injct_t;

   typedef enum logic [2:0] {
      TG_IDLE,
      TG_WAIT_RDY,
      TG_WRITE,
      TG_GAP,
      TG_DONE
   } tgen_state_t;

   // Round-robin successor over 0..NE-1 that never lands on the sender itself.
   function automatic logic [NEw-1:0] next_dest(input logic [NEw-1:0] cur,
                                                input logic [NEw-1:0] self_id);
      logic [NEw-1:0] n;
      n = (cur == NEw'(NE - 1)) ? '0 : cur + 1'b1;
      if (n == self_id) n = (n == NEw'(NE - 1)) ? '0 : n + 1'b1;
      return n;
   endfunction

endpackage

// File: rtl/pck_injct_traffic_gen_if.sv
// Write and status/receive sides of one packet_injector control port.
interface pck_injct_traffic_gen_if;
   import pck_injct_traffic_gen_pkg::*;

   pck_injct_t pck_injct_in;
   pck_injct_t pck_injct_out;

   modport master (output pck_injct_in, input pck_injct_out);
   modport slave  (input pck_injct_in, output pck_injct_out);
endinterface

// File: rtl/pck_injct_traffic_gen_endp_addr_encoder.sv
// Endpoint id to mesh endpoint address {y, x}; purely combinational.
module pck_injct_traffic_gen_endp_addr_encoder
   import pck_injct_traffic_gen_pkg::*;
(
   input  logic [NEw-1:0] id,
   output logic [EAw-1:0] endp_addr
);
   logic [Xw-1:0] x;
   logic [Yw-1:0] y;

   always_comb begin
      x         = Xw'(id % NEw'(T1));
      y         = Yw'(id / NEw'(T1));
      endp_addr = {y, x};
   end
endmodule

// File: rtl/pck_injct_traffic_gen.sv
// Per-endpoint traffic generator/checker: one-cycle write after ready[vc] seen, stalls while ready is low.
// Receive-latency statistics are built only when PCK_TGEN_LATENCY_EN is defined.
module pck_injct_traffic_gen
   import pck_injct_traffic_gen_pkg::*;
#(
   parameter int NUM_PCK   = 10,
   parameter int MIN_SIZE  = 3,
   parameter int MAX_SIZE  = 20,
   parameter int GAP       = 1,
   parameter int DEST_MODE = 0,
   parameter int DEST_ID   = 0,
   parameter int SELF_ID   = 0,
   parameter int VC_ROT    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   pck_injct_traffic_gen_if.master pck_injct,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             sent_cnt,
   output logic [15:0]             recv_cnt,
   output logic                    err,
   output logic [31:0]             lat_sum,
   output logic [15:0]             lat_max
);
   localparam int VCw = (V > 1) ? $clog2(V) : 1;
   localparam logic [NEw-1:0]      SELF      = NEw'(SELF_ID);
   localparam logic [NEw-1:0]      DEST_INIT = (DEST_MODE == 1) ? NEw'((SELF_ID + 1) % NE)
                                                                : NEw'(DEST_ID);
   localparam logic [PCK_SIZw-1:0] SZ_MIN    = PCK_SIZw'(MIN_SIZE);
   localparam logic [PCK_SIZw-1:0] SZ_MAX    = PCK_SIZw'(MAX_SIZE);
   localparam logic [PCK_SIZw-1:0] SZ_SPAN   = SZ_MAX - SZ_MIN;
   localparam logic [15:0]         LAST_SEQ  = 16'(NUM_PCK - 1);
   localparam logic [15:0]         GAP_LEN   = 16'(GAP);

   tgen_state_t         state, state_nxt;
   pck_injct_t          wr, rx;
   logic [PCK_SIZw-1:0] sz_off;
   logic [NEw-1:0]      dest;
   logic [EAw-1:0]      dest_addr;
   logic [VCw-1:0]      vc_idx;
   logic [15:0]         gap_cnt;
   logic [31:0]         stamp;
   logic                rdy, accept, run_start, size_bad;

   assign rx                     = pck_injct.pck_injct_out;
   assign pck_injct.pck_injct_in = wr;
   assign rdy                    = rx.ready[vc_idx];
   assign run_start              = start && (state == TG_IDLE || state == TG_DONE);
   assign size_bad               = (rx.size < SZ_MIN) || (rx.size > SZ_MAX);
   assign busy = (state == TG_WAIT_RDY) || (state == TG_WRITE) || (state == TG_GAP);
   assign done = (state == TG_DONE);

   pck_injct_traffic_gen_endp_addr_encoder u_enc (
      .id        (dest),
      .endp_addr (dest_addr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= TG_IDLE;
      else       state <= state_nxt;
   end

   // Ready is re-checked in WRITE so a drop after WAIT_RDY never lets pck_wr through.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      wr        = '0;
      case (state)
         TG_IDLE, TG_DONE: if (start) state_nxt = TG_WAIT_RDY;
         TG_WAIT_RDY:      if (rdy) state_nxt = TG_WRITE;
         TG_WRITE: begin
            wr.data        = Fpay'({SELF, sent_cnt, stamp});
            wr.size        = SZ_MIN + sz_off;
            wr.endp_addr   = dest_addr;
            wr.class_num   = '0;
            wr.init_weight = WEIGHTw'(1);
            wr.vc          = V'(1) << vc_idx;
            wr.pck_wr      = rdy;
            if (rdy) begin
               accept = 1'b1;
               if (sent_cnt == LAST_SEQ) state_nxt = TG_DONE;
               else if (GAP_LEN == 16'd0) state_nxt = TG_WAIT_RDY;
               else state_nxt = TG_GAP;
            end
         end
         TG_GAP:  if (gap_cnt <= 16'd1) state_nxt = TG_WAIT_RDY;
         default: state_nxt = TG_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sent_cnt <= '0;
         sz_off   <= '0;
         dest     <= DEST_INIT;
         vc_idx   <= '0;
         gap_cnt  <= '0;
      end else if (run_start) begin
         sent_cnt <= '0;
         sz_off   <= '0;
         dest     <= DEST_INIT;
         vc_idx   <= '0;
      end else if (accept) begin
         sent_cnt <= sent_cnt + 16'd1;
         sz_off   <= (sz_off == SZ_SPAN) ? '0 : sz_off + 1'b1;
         if (DEST_MODE == 1) dest <= next_dest(dest, SELF);
         if (VC_ROT == 1) vc_idx <= (vc_idx == VCw'(V - 1)) ? '0 : vc_idx + 1'b1;
         gap_cnt  <= GAP_LEN;
      end else if (state == TG_GAP) begin
         gap_cnt  <= gap_cnt - 16'd1;
      end
   end

   // A packet arriving in the same cycle as an accepted start is counted after the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         recv_cnt <= '0;
         err      <= 1'b0;
      end else if (run_start) begin
         recv_cnt <= {15'd0, rx.pck_wr};
         err      <= rx.pck_wr && size_bad;
      end else if (rx.pck_wr) begin
         if (recv_cnt != 16'hFFFF) recv_cnt <= recv_cnt + 16'd1;
         if (size_bad) err <= 1'b1;
      end
   end

`ifdef PCK_TGEN_LATENCY_EN
   logic [31:0] cyc_cnt, lat;
   logic [15:0] lat16;

   assign stamp = cyc_cnt;
   assign lat   = cyc_cnt - rx.data[31:0];
   assign lat16 = (|lat[31:16]) ? 16'hFFFF : lat[15:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cyc_cnt <= '0;
      else       cyc_cnt <= cyc_cnt + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_sum <= '0;
         lat_max <= '0;
      end else if (run_start) begin
         lat_sum <= rx.pck_wr ? lat : '0;
         lat_max <= rx.pck_wr ? lat16 : '0;
      end else if (rx.pck_wr) begin
         lat_sum <= lat_sum + lat;
         if (lat16 > lat_max) lat_max <= lat16;
      end
   end
`else
   assign stamp   = '0;
   assign lat_sum = '0;
   assign lat_max = '0;
`endif

endmodule

// File: tb/tb_pck_injct_traffic_gen.sv
// Directed bench: size sweep, loopback checking, round-robin destinations with VC rotation,
// ready stall, mid-run reset and loop latency statistics across four generator instances.
module tb_pck_injct_traffic_gen;
   import pck_injct_traffic_gen_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_a, start_b, start_c, start_d;
   logic busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic busy_c, done_c, err_c, busy_d, done_d, err_d;
   logic [15:0] sent_a, recv_a, lmax_a, sent_b, recv_b, lmax_b;
   logic [15:0] sent_c, recv_c, lmax_c, sent_d, recv_d, lmax_d;
   logic [31:0] lsum_a, lsum_b, lsum_c, lsum_d;

   pck_injct_traffic_gen_if ifa();
   pck_injct_traffic_gen_if ifb();
   pck_injct_traffic_gen_if ifc();
   pck_injct_traffic_gen_if ifd();

   pck_injct_t a_rx, b_rx, b_lb, b_inj, c_rx, d_rx;
   pck_injct_t d_pipe [7];
   logic       b_inj_on;

   assign ifa.pck_injct_out = a_rx;
   assign ifb.pck_injct_out = b_rx;
   assign ifc.pck_injct_out = c_rx;
   assign ifd.pck_injct_out = d_rx;

   always_comb begin
      b_rx       = b_inj_on ? b_inj : b_lb;
      b_rx.ready = '1;
   end

   always_comb begin
      d_rx       = d_pipe[6];
      d_rx.ready = '1;
   end

   // One-cycle loopback for B, seven-cycle loopback for D.
   always @(posedge clk) begin
      b_lb      <= rst ? '0 : ifb.pck_injct_in;
      d_pipe[0] <= rst ? '0 : ifd.pck_injct_in;
      for (int i = 1; i < 7; i++) d_pipe[i] <= rst ? '0 : d_pipe[i-1];
   end

   pck_injct_traffic_gen #(.NUM_PCK(10), .MIN_SIZE(3), .MAX_SIZE(20), .GAP(1), .DEST_MODE(0),
                           .DEST_ID(0), .SELF_ID(1), .VC_ROT(0)) dut_a (
      .clk(clk), .reset(rst), .start(start_a), .pck_injct(ifa), .busy(busy_a), .done(done_a),
      .sent_cnt(sent_a), .recv_cnt(recv_a), .err(err_a), .lat_sum(lsum_a), .lat_max(lmax_a));

   pck_injct_traffic_gen #(.NUM_PCK(10), .MIN_SIZE(4), .MAX_SIZE(4), .GAP(1), .DEST_MODE(0),
                           .DEST_ID(1), .SELF_ID(1), .VC_ROT(0)) dut_b (
      .clk(clk), .reset(rst), .start(start_b), .pck_injct(ifb), .busy(busy_b), .done(done_b),
      .sent_cnt(sent_b), .recv_cnt(recv_b), .err(err_b), .lat_sum(lsum_b), .lat_max(lmax_b));

   pck_injct_traffic_gen #(.NUM_PCK(5), .MIN_SIZE(3), .MAX_SIZE(5), .GAP(0), .DEST_MODE(1),
                           .DEST_ID(0), .SELF_ID(2), .VC_ROT(1)) dut_c (
      .clk(clk), .reset(rst), .start(start_c), .pck_injct(ifc), .busy(busy_c), .done(done_c),
      .sent_cnt(sent_c), .recv_cnt(recv_c), .err(err_c), .lat_sum(lsum_c), .lat_max(lmax_c));

   pck_injct_traffic_gen #(.NUM_PCK(3), .MIN_SIZE(3), .MAX_SIZE(20), .GAP(1), .DEST_MODE(0),
                           .DEST_ID(1), .SELF_ID(0), .VC_ROT(0)) dut_d (
      .clk(clk), .reset(rst), .start(start_d), .pck_injct(ifd), .busy(busy_d), .done(done_d),
      .sent_cnt(sent_d), .recv_cnt(recv_d), .err(err_d), .lat_sum(lsum_d), .lat_max(lmax_d));

   pck_injct_t wa_q[$];
   pck_injct_t wc_q[$];
   int viol_a = 0;

   always @(negedge clk) begin
      if (ifa.pck_injct_in.pck_wr === 1'b1) begin
         wa_q.push_back(ifa.pck_injct_in);
         if (a_rx.ready[0] !== 1'b1) viol_a++;
      end
      if (ifc.pck_injct_in.pck_wr === 1'b1) wc_q.push_back(ifc.pck_injct_in);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int exp_dest [5] = '{3, 0, 1, 3, 0};
   int exp_size [5] = '{3, 4, 5, 3, 4};
   int exp_vc   [5] = '{1, 2, 1, 2, 1};

   initial begin
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
      b_inj_on = 1'b0; b_inj = '0;
      a_rx = '0; a_rx.ready = '1;
      c_rx = '0; c_rx.ready = '1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_sent", 32'(sent_a), 0);
      check("rst_recv", 32'(recv_a), 0);
      check("rst_err", 32'(err_a), 0);
      check("rst_wr", 32'(ifa.pck_injct_in.pck_wr), 0);
      check("rst_size", 32'(ifa.pck_injct_in.size), 0);
      check("rst_lsum", lsum_d, 0);
      @(posedge clk); #1 rst = 1'b0;

      // 1: fixed destination, size sweep 3..12
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      for (int i = 0; i < 400 && done_a !== 1'b1; i++) @(negedge clk);
      check("t1_done", 32'(done_a), 1);
      check("t1_busy", 32'(busy_a), 0);
      check("t1_sent", 32'(sent_a), 10);
      check("t1_nwr", wa_q.size(), 10);
      for (int k = 0; k < 10; k++) begin
         if (k < wa_q.size()) begin
            check($sformatf("t1_size%0d", k), 32'(wa_q[k].size), 32'(3 + k));
            check($sformatf("t1_seq%0d", k), 32'(wa_q[k].data[49:32]), 32'((1 << 16) + k));
         end
      end
      if (wa_q.size() > 0) begin
         check("t1_addr", 32'(wa_q[0].endp_addr), 0);
         check("t1_vc", 32'(wa_q[0].vc), 1);
         check("t1_wgt", 32'(wa_q[0].init_weight), 1);
      end

      // 2: loopback with MIN=MAX=4, then out-of-range packets
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int i = 0; i < 400 && done_b !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("t2_sent", 32'(sent_b), 10);
      check("t2_recv", 32'(recv_b), 10);
      check("t2_err0", 32'(err_b), 0);
      @(posedge clk); #1 b_inj = '0; b_inj.pck_wr = 1'b1; b_inj.size = 8'd2; b_inj_on = 1'b1;
      @(posedge clk); #1 b_inj_on = 1'b0;
      @(negedge clk);
      check("t2_err_small", 32'(err_b), 1);
      check("t2_recv11", 32'(recv_b), 11);
      repeat (5) @(negedge clk);
      check("t2_err_sticky", 32'(err_b), 1);
      // start and a good packet in the same cycle: clear first, then count it
      @(posedge clk); #1 start_b = 1'b1; b_inj.size = 8'd4; b_inj_on = 1'b1;
      @(posedge clk); #1 start_b = 1'b0; b_inj_on = 1'b0;
      @(negedge clk);
      check("t2_clr_recv", 32'(recv_b), 1);
      check("t2_clr_err", 32'(err_b), 0);
      check("t2_clr_sent", 32'(sent_b), 0);
      for (int i = 0; i < 400 && done_b !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("t2_recv_run2", 32'(recv_b), 11);
      check("t2_err_run2", 32'(err_b), 0);
      @(posedge clk); #1 b_inj.size = 8'd5; b_inj_on = 1'b1;
      @(posedge clk); #1 b_inj_on = 1'b0;
      @(negedge clk);
      check("t2_err_big", 32'(err_b), 1);
      check("t2_recv12", 32'(recv_b), 12);

      // 3: round-robin destinations, size wrap, VC rotation, no gap
      @(posedge clk); #1 start_c = 1'b1;
      @(posedge clk); #1 start_c = 1'b0;
      for (int i = 0; i < 400 && done_c !== 1'b1; i++) @(negedge clk);
      check("t3_done", 32'(done_c), 1);
      check("t3_nwr", wc_q.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < wc_q.size()) begin
            check($sformatf("t3_dest%0d", k), 32'(wc_q[k].endp_addr), exp_dest[k]);
            check($sformatf("t3_size%0d", k), 32'(wc_q[k].size), exp_size[k]);
            check($sformatf("t3_vc%0d", k), 32'(wc_q[k].vc), exp_vc[k]);
         end
      end
      if (wc_q.size() > 0) check("t3_self", 32'(wc_q[0].data[49:48]), 2);

      // 6: seven-cycle loop latency
      @(posedge clk); #1 start_d = 1'b1;
      @(posedge clk); #1 start_d = 1'b0;
      for (int i = 0; i < 400 && done_d !== 1'b1; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("t6_recv", 32'(recv_d), 3);
      check("t6_err", 32'(err_d), 0);
`ifdef PCK_TGEN_LATENCY_EN
      check("t6_lat_sum", lsum_d, 21);
      check("t6_lat_max", 32'(lmax_d), 7);
`else
      check("t6_lat_sum", lsum_d, 0);
      check("t6_lat_max", 32'(lmax_d), 0);
`endif

      // 4: ready[0] held low for 50 cycles
      @(posedge clk); #1 a_rx.ready = 2'b10; wa_q.delete(); start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (50) @(negedge clk);
      check("t4_no_wr", wa_q.size(), 0);
      check("t4_busy", 32'(busy_a), 1);
      check("t4_sent", 32'(sent_a), 0);
      @(posedge clk); #1 a_rx.ready = 2'b11;
      @(negedge clk);
      check("t4_rel_same", 32'(ifa.pck_injct_in.pck_wr), 0);
      @(negedge clk);
      check("t4_rel_next", 32'(ifa.pck_injct_in.pck_wr), 1);

      // 5: reset during the gap after the 4th packet
      for (int i = 0; i < 100 && sent_a != 16'd4; i++) @(negedge clk);
      check("t5_sent4", 32'(sent_a), 4);
      check("t5_gap_wr", 32'(ifa.pck_injct_in.pck_wr), 0);
      check("t5_gap_busy", 32'(busy_a), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_rst_busy", 32'(busy_a), 0);
      check("t5_rst_done", 32'(done_a), 0);
      check("t5_rst_sent", 32'(sent_a), 0);
      check("t5_rst_wr", 32'(ifa.pck_injct_in.pck_wr), 0);
      check("t5_rst_recv", 32'(recv_b), 0);
      check("t5_rst_err", 32'(err_b), 0);
      check("t4_ready_viol", viol_a, 0);
      rst = 1'b0;
      @(posedge clk); #1 wa_q.delete(); start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      @(negedge clk);
      check("t5_restart_sent", 32'(sent_a), 0);
      for (int i = 0; i < 400 && done_a !== 1'b1; i++) @(negedge clk);
      check("t5_done", 32'(done_a), 1);
      check("t5_sent10", 32'(sent_a), 10);
      check("t5_nwr", wa_q.size(), 10);
      if (wa_q.size() > 0) begin
         check("t5_seq0", 32'(wa_q[0].data[47:32]), 0);
         check("t5_size0", 32'(wa_q[0].size), 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
